// File: rtl/load_store_unit.sv
// Load/store unit: turns a held controller memory request into a valid/ready bus access,
// with store lane steering, load extension and a bus timeout. Optional: MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        bus_valid_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [31:0]     bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]      bus_wstrb_q;
  logic            bus_err_q, misalign_q;
  logic [TO_W-1:0] cnt_q;

  logic        req, mis_req, latch, go_mis, load_done, to_fire, timeout_hit;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, load_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req         = req_read_i | req_write_i;
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

`ifdef MISALIGN_TRAP_EN
  assign mis_req = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   (funct3_i[1] && (addr_i[1:0] != 2'b00));
`else
  assign mis_req = 1'b0;
`endif

  // Store steering; funct3[1:0] selects size, anything not byte/half is a word.
  always_comb begin
    wstrb_d = 4'b1111;
    wdata_d = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wstrb_d = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_b = bus_rdata_i[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

  // funct3[2] set means unsigned (lbu/lhu).
  always_comb begin
    load_d = bus_rdata_i;
    case (funct3_q[1:0])
      2'b00:   load_d = {{24{~funct3_q[2] & lane_b[7]}}, lane_b};
      2'b01:   load_d = {{16{~funct3_q[2] & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    go_mis    = 1'b0;
    load_done = 1'b0;
    to_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (mis_req) begin
            go_mis  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (bus_ready_i) begin
          load_done = 1'b1;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          to_fire = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      bus_err_q  <= to_fire;
      misalign_q <= go_mis;
      if (latch) begin
        funct3_q <= funct3_i;
        off_q    <= addr_i[1:0];
        if (!mis_req) begin
          we_q        <= req_write_i;
          bus_addr_q  <= {addr_i[31:2], 2'b00};
          bus_wstrb_q <= wstrb_d;
          bus_wdata_q <= wdata_d;
        end
      end
      if (state_q == S_BUS && !bus_ready_i && !timeout_hit)
        cnt_q <= cnt_q + TO_W'(1);
      else
        cnt_q <= '0;
      if (load_done && !we_q)
        rdata_q <= load_d;
      else if (to_fire || go_mis)
        rdata_q <= '0;
    end
  end

  // bus_valid decodes state only, so reset drops it immediately.
  assign bus_valid_o = (state_q == S_BUS);
  assign stall_o     = req & (state_q != S_DONE);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wstrb_o = bus_wstrb_q;
  assign bus_wdata_o = bus_wdata_q;
  assign rdata_o     = rdata_q;
  assign bus_err_o   = bus_err_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected bus beats and completions,
// a monitor pops and compares them when the DUT presents them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err, misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_read_i(req_read), .req_write_i(req_write),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .rdata_o(rdata),
    .bus_valid_o(bus_valid), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
    .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata),
    .bus_err_o(bus_err), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  // Monitor: bus beats checked every valid cycle (stability), popped on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus_valid) begin
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: bus_valid=1 addr=%h with nothing expected", bus_addr);
        end else begin
          checks++;
          if (bus_addr !== bus_q[0].addr || bus_we !== bus_q[0].we ||
              (bus_q[0].we && (bus_wstrb !== bus_q[0].wstrb || bus_wdata !== bus_q[0].wdata))) begin
            errors++;
            $display("FAIL bus_beat: got addr=%h we=%b strb=%b wd=%h, want addr=%h we=%b strb=%b wd=%h",
                     bus_addr, bus_we, bus_wstrb, bus_wdata,
                     bus_q[0].addr, bus_q[0].we, bus_q[0].wstrb, bus_q[0].wdata);
          end
          if (bus_ready) void'(bus_q.pop_front());
        end
      end
      if ((req_read || req_write) && !stall) begin
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: completion with nothing expected, rdata=%h", rdata);
        end else begin
          rsp_exp_t e;
          e = rsp_q.pop_front();
          checks++;
          if (rdata !== e.rdata || bus_err !== e.err || misalign !== e.mis) begin
            errors++;
            $display("FAIL completion: got rdata=%h err=%b mis=%b, want rdata=%h err=%b mis=%b",
                     rdata, bus_err, misalign, e.rdata, e.err, e.mis);
          end
        end
      end else if (bus_err || misalign) begin
        errors++;
        $display("FAIL pulse_width: err=%b mis=%b outside completion cycle", bus_err, misalign);
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                           input int waitc, input bit never, input int exp_stall,
                           input bit exp_bus, input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input bit exp_err, input bit exp_mis);
    bus_exp_t b;
    rsp_exp_t r;
    int nstall = 0;
    int wcnt = 0;
    bit done = 0;
    if (exp_bus) begin
      b.addr = {a[31:2], 2'b00}; b.we = wr; b.wstrb = exp_strb; b.wdata = exp_wd;
      bus_q.push_back(b);
    end
    r.rdata = exp_rd; r.err = exp_err; r.mis = exp_mis;
    rsp_q.push_back(r);
    @(negedge clk);
    req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rword; bus_ready = 1'b0;
    #1;
    if (stall) nstall++;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus_ready = bus_valid && !never && (wcnt >= waitc);
      if (bus_valid) wcnt++;
      #1;
      if (!stall) done = 1;
      else nstall++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: no completion at addr=%h within budget", a);
    end else if (nstall != exp_stall) begin
      errors++;
      $display("FAIL stall_cycles: addr=%h got %0d want %0d", a, nstall, exp_stall);
    end
    if (never && bus_q.size() != 0) void'(bus_q.pop_front());
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0; bus_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || bus_err !== 1'b0 ||
        misalign !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
        bus_wstrb !== 4'h0 || bus_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b stall=%b rdata=%h err=%b mis=%b we=%b addr=%h strb=%b wd=%h, want all 0",
               bus_valid, stall, rdata, bus_err, misalign, bus_we, bus_addr, bus_wstrb, bus_wdata);
    end
    @(negedge clk);
    rst = 1'b0;

    // rd wr f3 addr wdata rword wait never stall bus strb wd rdata err mis
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 2, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0, 2, 1, 4'hF, 32'h0, 32'hFFFFFF80, 0, 0);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0, 2, 1, 4'hF, 32'h0, 32'h00000080, 0, 0);
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0, 0, 2, 1, 4'hF, 32'h0, 32'h00008011, 0, 0);
    do_access(1, 0, 3'b000, 32'h102, 32'h0, 32'h00347F00, 1, 0, 3, 1, 4'hF, 32'h0, 32'h00000034, 0, 0);
    do_access(1, 0, 3'b011, 32'h104, 32'h0, 32'hA5A50F0F, 0, 0, 2, 1, 4'hF, 32'h0, 32'hA5A50F0F, 0, 0);
    do_access(1, 0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 0, 0, 2, 1, 4'hF, 32'h0, 32'hFFFFF00D, 0, 0);
    do_access(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0, 0, 2, 1, 4'b0010, 32'hABABABAB, 32'hFFFFF00D, 0, 0);
    do_access(0, 1, 3'b001, 32'h202, 32'h0000CAFE, 32'h0, 3, 0, 5, 1, 4'b1100, 32'hCAFECAFE, 32'hFFFFF00D, 0, 0);
    do_access(0, 1, 3'b010, 32'h30C, 32'h11223344, 32'h0, 0, 0, 2, 1, 4'b1111, 32'h11223344, 32'hFFFFF00D, 0, 0);
    do_access(1, 1, 3'b010, 32'h040, 32'h00000055, 32'h0, 0, 0, 2, 1, 4'b1111, 32'h00000055, 32'hFFFFF00D, 0, 0);
    do_access(1, 0, 3'b010, 32'h500, 32'h0, 32'h12345678, 0, 1, 5, 1, 4'hF, 32'h0, 32'h00000000, 1, 0);
    do_access(1, 0, 3'b010, 32'h108, 32'h0, 32'h0BADF00D, 2, 0, 4, 1, 4'hF, 32'h0, 32'h0BADF00D, 0, 0);
`ifdef MISALIGN_TRAP_EN
    do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEBABE, 0, 0, 1, 0, 4'hF, 32'h0, 32'h00000000, 0, 1);
    do_access(0, 1, 3'b001, 32'h201, 32'h00001234, 32'h0, 0, 0, 1, 0, 4'hF, 32'h0, 32'h00000000, 0, 1);
`else
    do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEBABE, 0, 0, 2, 1, 4'hF, 32'h0, 32'hCAFEBABE, 0, 0);
    do_access(1, 0, 3'b101, 32'h103, 32'h0, 32'h80112233, 0, 0, 2, 1, 4'hF, 32'h0, 32'h00008011, 0, 0);
`endif

    // Abandon a load mid-BUS with reset.
    begin
      bus_exp_t b;
      b.addr = 32'h600; b.we = 1'b0; b.wstrb = 4'hF; b.wdata = 32'h0;
      bus_q.push_back(b);
      @(negedge clk);
      req_read = 1'b1; funct3 = 3'b010; addr = 32'h600; bus_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus_valid !== 1'b0 || rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid_bus: bus_valid=%b rdata=%h, want 0 and 0", bus_valid, rdata);
      end
      req_read = 1'b0;
      bus_q.delete();
      @(negedge clk);
      rst = 1'b0;
    end

    do_access(1, 0, 3'b100, 32'h701, 32'h0, 32'h0000C300, 0, 0, 2, 1, 4'hF, 32'h0, 32'h000000C3, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: bus_q=%0d rsp_q=%0d left, want 0 and 0", bus_q.size(), rsp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
